// File: rtl/sad_min_tracker.sv
// Pipelined minimum-SAD selector: a registered pairwise tree reduces each beat
// to one winner, and an accumulator keeps the best winner across a search window.
module sad_min_tracker #(
  parameter int SAD_W = 32,
  parameter int IDX_W = 32,
  parameter int LANES = 4,
  parameter int CNT_W = 16
) (
  input  logic                   Clk,
  input  logic                   Rst,
  input  logic                   start,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_last,
  input  logic [LANES*SAD_W-1:0] in_sad,
  input  logic [LANES*IDX_W-1:0] in_idx,
  input  logic [LANES-1:0]       in_mask,
  output logic                   out_valid,
  output logic [SAD_W-1:0]       best_sad,
  output logic [IDX_W-1:0]       best_idx,
  output logic [CNT_W-1:0]       cand_count,
  output logic                   none_valid,
  output logic                   busy
);

  localparam int L    = $clog2(LANES);
  localparam int HALF = LANES / 2;
  localparam int PW   = $clog2(LANES) + 1;

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;
  state_t state, state_nxt;

  logic accept;

  // src_* is the combinational input of tree level s; p_* is its registered output.
  logic [SAD_W-1:0] src_sad  [L][LANES];
  logic [IDX_W-1:0] src_idx  [L][LANES];
  logic             src_v    [L][LANES];
  logic             src_tok  [L];
  logic             src_last [L];
  logic [PW-1:0]    src_pc   [L];

  logic [SAD_W-1:0] p_sad    [L][HALF];
  logic [IDX_W-1:0] p_idx    [L][HALF];
  logic             p_v      [L][HALF];
  logic             tok_v    [L];
  logic             tok_last [L];
  logic [PW-1:0]    tok_pc   [L];

  logic [SAD_W-1:0] acc_sad;
  logic [IDX_W-1:0] acc_idx;
  logic             acc_v;
  logic [CNT_W-1:0] acc_cnt;
  logic             done;
  logic [CNT_W:0]   cnt_sum;

  function automatic logic pick_right(input logic vl, input logic vr,
                                      input logic [SAD_W-1:0] sl,
                                      input logic [SAD_W-1:0] sr);
    return vr && (!vl || (sr < sl));
  endfunction

  assign in_ready   = (state == RUN);
  assign busy       = (state != IDLE);
  assign accept     = in_valid && in_ready;
  assign best_sad   = acc_sad;
  assign best_idx   = acc_idx;
  assign cand_count = acc_cnt;
  assign none_valid = !acc_v;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (start) state_nxt = RUN;
               else if (accept && in_last) state_nxt = FLUSH;
      FLUSH:   if (start) state_nxt = RUN;
               else if (out_valid) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    for (int s = 0; s < L; s++) begin
      for (int k = 0; k < LANES; k++) begin
        src_sad[s][k] = '0;
        src_idx[s][k] = '0;
        src_v[s][k]   = 1'b0;
      end
      src_tok[s]  = 1'b0;
      src_last[s] = 1'b0;
      src_pc[s]   = '0;
    end
    for (int k = 0; k < LANES; k++) begin
      src_sad[0][k] = in_sad[k*SAD_W +: SAD_W];
      src_idx[0][k] = in_idx[k*IDX_W +: IDX_W];
      src_v[0][k]   = in_mask[k];
      src_pc[0]     = src_pc[0] + PW'(in_mask[k]);
    end
    src_tok[0]  = accept;
    src_last[0] = in_last;
    for (int s = 1; s < L; s++) begin
      for (int k = 0; k < HALF; k++) begin
        src_sad[s][k] = p_sad[s-1][k];
        src_idx[s][k] = p_idx[s-1][k];
        src_v[s][k]   = p_v[s-1][k];
      end
      src_tok[s]  = tok_v[s-1];
      src_last[s] = tok_last[s-1];
      src_pc[s]   = tok_pc[s-1];
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      for (int s = 0; s < L; s++) begin
        for (int j = 0; j < HALF; j++) begin
          p_sad[s][j] <= '0;
          p_idx[s][j] <= '0;
          p_v[s][j]   <= 1'b0;
        end
        tok_v[s]    <= 1'b0;
        tok_last[s] <= 1'b0;
        tok_pc[s]   <= '0;
      end
    end else begin
      for (int s = 0; s < L; s++) begin
        for (int j = 0; j < (LANES >> (s + 1)); j++) begin
          if (pick_right(src_v[s][2*j], src_v[s][2*j+1], src_sad[s][2*j], src_sad[s][2*j+1])) begin
            p_sad[s][j] <= src_sad[s][2*j+1];
            p_idx[s][j] <= src_idx[s][2*j+1];
          end else begin
            p_sad[s][j] <= src_sad[s][2*j];
            p_idx[s][j] <= src_idx[s][2*j];
          end
          p_v[s][j] <= !start && (src_v[s][2*j] || src_v[s][2*j+1]);
        end
        tok_v[s]    <= !start && src_tok[s];
        tok_last[s] <= src_last[s];
        tok_pc[s]   <= src_pc[s];
      end
    end
  end

  assign cnt_sum = {1'b0, acc_cnt} + (CNT_W+1)'(tok_pc[L-1]);

  // Strict less-than on both the tree and here keeps ties on the earliest candidate.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      acc_sad   <= '1;
      acc_idx   <= '0;
      acc_v     <= 1'b0;
      acc_cnt   <= '0;
      done      <= 1'b0;
      out_valid <= 1'b0;
    end else if (start) begin
      acc_sad   <= '1;
      acc_idx   <= '0;
      acc_v     <= 1'b0;
      acc_cnt   <= '0;
      done      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= done;
      done      <= tok_v[L-1] && tok_last[L-1];
      if (tok_v[L-1]) begin
        if (p_v[L-1][0] && (!acc_v || (p_sad[L-1][0] < acc_sad))) begin
          acc_sad <= p_sad[L-1][0];
          acc_idx <= p_idx[L-1][0];
          acc_v   <= 1'b1;
        end
        acc_cnt <= cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];
      end
    end
  end

endmodule

// File: doc/sad_min_tracker.md
# sad_min_tracker

Streaming, pipelined minimum-SAD selector for the motion-estimation datapath. Each beat carries `LANES` candidate SAD/index pairs. A registered comparison tree reduces each beat to one winner, and a running accumulator keeps the best winner across a whole search window. When the beat marked `in_last` has been absorbed, the block emits a single-cycle result. It sits between the SAD computation array and the motion-vector output logic, and replaces the purely combinational two-input comparator stages.

## Interface
Parameters:
- `SAD_W`, 32, width of one SAD value (unsigned).
- `IDX_W`, 32, width of one candidate index.
- `LANES`, 4, candidates per beat; power of two, 2..16.
- `CNT_W`, 16, width of the valid-candidate counter.

Ports:
- `Clk`  in  1  clock; all state changes on the rising edge.
- `Rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle pulse that opens a new search.
- `in_valid`  in  1  beat present on `in_sad`/`in_idx`/`in_mask`.
- `in_ready`  out  1  beat accepted when `in_valid && in_ready`.
- `in_last`  in  1  qualifies the final beat of the search.
- `in_sad`  in  LANES*SAD_W  lane k occupies bits [k*SAD_W +: SAD_W].
- `in_idx`  in  LANES*IDX_W  lane k occupies bits [k*IDX_W +: IDX_W].
- `in_mask`  in  LANES  bit k=1 means lane k is a valid candidate.
- `out_valid`  out  1  one-cycle pulse carrying the result.
- `best_sad`  out  SAD_W  minimum SAD of the search.
- `best_idx`  out  IDX_W  index paired with `best_sad`.
- `cand_count`  out  CNT_W  number of valid lanes accepted; saturates at all-ones.
- `none_valid`  out  1  search contained zero valid lanes; meaningful with `out_valid`.
- `busy`  out  1  high whenever the FSM is not in IDLE.

## Operation
- Define L = log2(LANES).
- FSM states:
  - IDLE: `in_ready`=0. `start` moves to RUN and clears the accumulator.
  - RUN: `in_ready`=1. An accepted beat with `in_last` moves to FLUSH.
  - FLUSH: `in_ready`=0. When the last beat's token leaves the accumulator stage, the block pulses `out_valid` and returns to IDLE.
- Accumulator clear:
  - SAD set to all-ones, index to 0, valid flag to 0, `cand_count` to 0.
- Comparison tree:
  - L registered stages, each comparing adjacent pairs.
  - Every pair element carries a per-candidate valid bit, derived from `in_mask`.
  - Winner selection: if only one side is valid, that side wins. If both are valid, the right side wins only if its SAD is strictly less; otherwise left wins. Ties therefore go to the lower lane.
- Accumulator stage:
  - A beat winner replaces the running best only if it is valid and either the running best is invalid or the winner's SAD is strictly less than the running best.
  - Ties keep the earlier beat.
  - A fully masked beat changes nothing.
- `cand_count` adds popcount(`in_mask`) for every accepted beat. The add is done at the accumulator stage and saturates.
- Result:
  - `none_valid` = !accumulator valid.
  - When `none_valid`=1, `best_sad` is all-ones and `best_idx` is 0.
  - `best_sad`, `best_idx`, `cand_count` and `none_valid` hold their values until the next `start`.
- `start` while in RUN or FLUSH aborts the current search:
  - All pipeline valid bits are cleared.
  - The accumulator is cleared.
  - The FSM stays in or re-enters RUN.
  - No `out_valid` is produced for the aborted search.
- `in_valid` outside RUN is ignored.
- Masked lanes are ignored regardless of their SAD/index contents.

## Timing
- Reset values: FSM IDLE, `out_valid`=0, `in_ready`=0, `busy`=0, `best_sad`=all-ones, `best_idx`=0, `cand_count`=0, `none_valid`=1. All pipeline valid bits are 0.
- Throughput: one beat per cycle while in RUN, with no bubbles.
- Latency: if the `in_last` beat is accepted at edge t, `out_valid` is high during the cycle following edge t+L+1.
- `in_ready` first rises on the edge after `start` is sampled in IDLE.
- `busy` rises together with the entry into RUN and falls on the same edge as `out_valid` falls.
- A `start` in the same cycle as `out_valid` is legal and opens the next search immediately.
- `Rst` asserted mid-search:
  - Forces the reset values immediately and asynchronously.
  - Any in-flight result is lost.

## Test plan
- LANES=4, `start`, then a single beat with SADs {40,12,12,90}, idx {0,1,2,3}, mask 1111, `in_last`=1: `out_valid` on the 3rd cycle after acceptance, `best_sad`=12, `best_idx`=1, `cand_count`=4.
- 3 back-to-back beats with minima 30, 7, 7 (idx 5, 9, 14), last on beat 3: `best_sad`=7, `best_idx`=9 (earlier beat wins the tie), `cand_count`=12.
- Mask 0000 on every beat of a 2-beat search: `none_valid`=1, `best_sad`=32'hFFFFFFFF, `best_idx`=0, `cand_count`=0.
- Mask 0100 with lane 2 SAD=500 while masked lanes carry 0: `best_sad`=500, `best_idx`=lane 2's index.
- `start` pulsed after 2 of 4 beats, then 1 fresh beat with min SAD 3 and `in_last`: exactly one `out_valid`, `best_sad`=3, and `cand_count` reflects only the new beat.
- `Rst` asserted during FLUSH: no `out_valid`, all outputs return to their reset values, and a following search completes normally.
